ras_stack: RTL
==============

Name: ras_stack

Overview:
- Parametrised return-address stack for the MUSA IF stage; successor to the fixed 8×13-bit PC stack.
- Holds CALL return addresses. Presents the top-of-stack (TOS) to the PC mux every cycle.
- Adds: configurable width and depth, simultaneous push+pop, an occupancy count, separate sticky overflow/underflow flags, and an error clear.
- Sits between the control unit (push/pop strobes) and the PC next-address mux.

Parameters:
- ADDR_W, 13, width of each stored PC.
- DEPTH, 8, number of entries; must be ≥2.
- LVL_W, $clog2(DEPTH+1), width of the level count (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  store push_addr as the new TOS (CALL).
- pop  in  1  discard the TOS (RET); the caller samples top_addr in the same cycle.
- push_addr  in  ADDR_W  return address to store.
- clear_err  in  1  clears the sticky overflow and underflow flags.
- top_addr  out  ADDR_W  registered TOS value; 0 when the stack is empty.
- level  out  LVL_W  number of valid entries, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- overflow  out  1  sticky; set on a rejected push.
- underflow  out  1  sticky; set on a pop while empty.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - reset=1 at the edge: level=0, top_addr=0, overflow=0, underflow=0.
  - Reset has priority over every other input, including an operation in flight.
  - Storage array contents are not reset.
- TOS handling:
  - TOS is held in a dedicated register; entries below it live in the storage array.
  - No read latency: top_addr is always valid in the cycle pop is asserted.
  - After a push of X at edge n, top_addr==X from cycle n+1.
- Operations per edge (push, pop):
  - 0,0: hold all state.
  - 1,0, not full: old TOS moves into array[level-1]; TOS←push_addr; level+1.
  - 1,0, full (macro off): push rejected; state unchanged; overflow←1.
  - 0,1, not empty: TOS←array[level-2], or 0 if level==1; level-1.
  - 0,1, empty: no change; underflow←1.
  - 1,1, not empty: TOS←push_addr; level unchanged; no flag set, even when full (tail-call/replace).
  - 1,1, empty: underflow←1; push proceeds; TOS←push_addr; level=1.
- Flags:
  - overflow and underflow are sticky until clear_err or reset.
  - If clear_err and a new error occur in the same edge, the flag ends up set (set wins).
- Combinational outputs: empty and full are decoded from the level register (no extra register).
- Width rules: level arithmetic is unsigned in LVL_W bits; push_addr is stored unmodified.

Optional Feature:
- Macro: RAS_WRAP_EN.
- Defined:
  - Push when full is accepted. The oldest entry (array[0]) is discarded, remaining entries shift down one slot, and the new address becomes TOS.
  - level stays at DEPTH; overflow is still set, as a diagnostic.
  - Implementation may use a circular base pointer instead of a physical shift, provided the observable behaviour matches.
- Undefined: push when full is rejected, as specified above.

Decomposition:
- Package musa_if_pkg:
  - PC_W=13 default.
  - RAS_DEPTH=8 default.
  - enum ras_op_t {RAS_NOP, RAS_PUSH, RAS_POP, RAS_REPL}, used to decode {push,pop}.
- Sub-module ras_storage:
  - (DEPTH-1)×ADDR_W register array.
  - One write port, one read port.
  - Read is combinational on index.
  - Wrap/shift support under RAS_WRAP_EN.
- Control (level, TOS, flags) stays in ras_stack.

Test Plan:
1. Reset, then push 0x0100, 0x0200, 0x0300 on consecutive cycles → top_addr=0x0300, level=3. Three pops → top_addr shows 0x0300, 0x0200, 0x0100 in the pop cycles, then 0; empty=1.
2. Push 0x1000+i for i=0..7 (DEPTH=8) → full=1. A 9th push 0x1FFF with macro off → overflow=1, top_addr=0x1007, level=8. Then clear_err → overflow=0.
3. Pop when empty → underflow=1, level=0. Then push+pop with push_addr 0x0042 → level=1, top_addr=0x0042, underflow stays 1.
4. Push 0x0A0A, 0x0B0B; then push+pop with 0x0C0C → level=2, top_addr=0x0C0C. Pop → top_addr=0x0A0A.
5. RAS_WRAP_EN defined: push 1..9 → level=8, overflow=1. Eight pops return 9,8,…,2; a further pop sets underflow.
6. Push three values; assert reset together with push=1 → next cycle level=0, top_addr=0, flags 0. A pop then sets underflow.

Source files
------------

// File: rtl/musa_if_pkg.sv
// Shared IF-stage types and defaults for the MUSA return-address stack.
package musa_if_pkg;

    localparam int PC_W      = 13;
    localparam int RAS_DEPTH = 8;

    typedef enum logic [1:0] {
        RAS_NOP,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL
    } ras_op_t;

    function automatic ras_op_t ras_decode(input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return RAS_PUSH;
            2'b01:   return RAS_POP;
            2'b11:   return RAS_REPL;
            default: return RAS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/ras_stack_storage.sv
// Storage for the entries below the TOS: one write port, combinational read.
// With RAS_WRAP_EN defined, a shift strobe drops entry 0 and appends wdata at the top slot.
module ras_storage
    import musa_if_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = RAS_DEPTH,
    parameter int IDX_W  = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
`ifdef RAS_WRAP_EN
    input  logic              shift,
`endif
    input  logic [IDX_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH-1];

    always_ff @(posedge clk) begin
`ifdef RAS_WRAP_EN
        if (shift) begin
            for (int i = 0; i < DEPTH - 2; i++) begin
                mem[i] <= mem[i+1];
            end
            mem[DEPTH-2] <= wdata;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
`else
        if (we) begin
            mem[waddr] <= wdata;
        end
`endif
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ras_stack.sv
// Return-address stack: TOS register, level count and sticky error flags over ras_storage.
// Optional macro RAS_WRAP_EN: a push when full discards the oldest entry instead of being rejected.
module ras_stack
    import musa_if_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = RAS_DEPTH,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] top_addr,
    output logic [LVL_W-1:0]  level,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    ras_op_t           op;
    logic [ADDR_W-1:0] tos, tos_next, rd_data;
    logic [LVL_W-1:0]  level_next;
    logic              set_ovf, set_unf, wr_en;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
`ifdef RAS_WRAP_EN
    logic              shift;
`endif

    assign op       = ras_decode(push, pop);
    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign top_addr = tos;

    // Array slot level-1 receives the old TOS on push; slot level-2 becomes TOS on pop.
    assign wr_idx = IDX_W'(level - LVL_W'(1));
    assign rd_idx = IDX_W'(level - LVL_W'(2));

    always_comb begin
        tos_next   = tos;
        level_next = level;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        wr_en      = 1'b0;
`ifdef RAS_WRAP_EN
        shift      = 1'b0;
`endif
        case (op)
            RAS_PUSH: begin
                if (!full) begin
                    wr_en      = !empty;
                    tos_next   = push_addr;
                    level_next = level + LVL_W'(1);
                end else begin
                    set_ovf = 1'b1;
`ifdef RAS_WRAP_EN
                    shift    = 1'b1;
                    tos_next = push_addr;
`else
                    tos_next = tos;
`endif
                end
            end
            RAS_POP: begin
                if (empty) begin
                    set_unf = 1'b1;
                end else begin
                    tos_next   = (level == LVL_W'(1)) ? '0 : rd_data;
                    level_next = level - LVL_W'(1);
                end
            end
            RAS_REPL: begin
                // Replacing TOS never touches the array; on empty it degenerates to a first push.
                tos_next = push_addr;
                if (empty) begin
                    set_unf    = 1'b1;
                    level_next = LVL_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos       <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tos       <= tos_next;
            level     <= level_next;
            overflow  <= (overflow & ~clear_err) | set_ovf;
            underflow <= (underflow & ~clear_err) | set_unf;
        end
    end

    ras_storage #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en & ~reset),
        .waddr (wr_idx),
        .wdata (tos),
`ifdef RAS_WRAP_EN
        .shift (shift & ~reset),
`endif
        .raddr (rd_idx),
        .rdata (rd_data)
    );

endmodule
